// File: rtl/expr_tx_if.sv
// Character stream link between the expression transmitter and its sink.
// Carries one 8-bit ASCII character per accepted transfer.
// Valid/ready handshake: a transfer happens on an edge where out_valid & out_ready.
interface expr_tx_if;
  logic [7:0] out_ch;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_ch, output out_valid, input out_ready);
  modport slave  (input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/expr_tx.sv
// Serializes a latched digit/operator list as ASCII and evaluates it (* before +).
// Latency: first character visible the cycle after the start edge; done one cycle after the last transfer.
// Backpressure: out_ch/out_valid hold while out_ready is low; start is ignored while busy.
module expr_tx #(
  parameter int MAXN = 8,
  parameter int W    = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [3:0]          count,
  input  logic [4*MAXN-1:0]   digits,
  input  logic [MAXN-2:0]     ops,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        result,
  output logic                err,
  expr_tx_if.master           tx
);

  localparam logic [3:0] MAXN4 = 4'(MAXN);

  typedef enum logic [1:0] {IDLE, DIGIT, OP, DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt_q, idx_q;
  logic [4*MAXN-1:0]   dig_q;
  logic [MAXN-2:0]     ops_q;
  logic [W-1:0]        sum_q, prod_q, sum_nx, prod_nx, dig_w;
  logic [3:0]          cur_dig, nxt_dig;
  logic                cur_op, prev_op;
  logic                xfer, start_ok, last_dig;

  assign xfer     = tx.out_valid & tx.out_ready;
  assign start_ok = start && (count != 4'd0) && (count <= MAXN4);
  assign last_dig = (idx_q == cnt_q - 4'd1);
  assign dig_w    = {{(W-4){1'b0}}, cur_dig};

  // Select the current and next operand and the operators either side of the current operand.
  always_comb begin
    cur_dig = 4'd0;
    nxt_dig = 4'd0;
    cur_op  = 1'b0;
    prev_op = 1'b0;
    for (int k = 0; k < MAXN; k++) begin
      if (idx_q == 4'(k))         cur_dig = dig_q[4*k +: 4];
      if (idx_q + 4'd1 == 4'(k))  nxt_dig = dig_q[4*k +: 4];
    end
    for (int k = 0; k < MAXN-1; k++) begin
      if (idx_q == 4'(k))         cur_op  = ops_q[k];
      if (idx_q == 4'(k+1))       prev_op = ops_q[k];
    end
  end

  // Precedence evaluation: prod holds the running product term, sum the finished terms.
  always_comb begin
    sum_nx  = sum_q;
    prod_nx = prod_q;
    if (idx_q == 4'd0) begin
      sum_nx  = '0;
      prod_nx = dig_w;
    end else if (!prev_op) begin
      sum_nx  = sum_q + prod_q;
      prod_nx = dig_w;
    end else begin
      prod_nx = prod_q * dig_w;
    end
  end

  // Next-state logic: advance on transfers, DONE lasts exactly one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_ok) state_nx = DIGIT;
      DIGIT: if (xfer)     state_nx = last_dig ? DONE : OP;
      OP:    if (xfer)     state_nx = DIGIT;
      DONE:                state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Registered outputs, latched request and accumulators; the next character is loaded on each transfer.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      dig_q        <= '0;
      ops_q        <= '0;
      sum_q        <= '0;
      prod_q       <= '0;
      result       <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tx.out_valid <= 1'b0;
      tx.out_ch    <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt_q        <= count;
            dig_q        <= digits;
            ops_q        <= ops;
            idx_q        <= '0;
            sum_q        <= '0;
            prod_q       <= '0;
            result       <= '0;
            err          <= 1'b0;
            busy         <= 1'b1;
            tx.out_valid <= 1'b1;
            tx.out_ch    <= 8'h30 + {4'h0, digits[3:0]};
          end else if (start) begin
            err <= 1'b1;
          end
        end
        DIGIT: begin
          if (xfer) begin
            sum_q  <= sum_nx;
            prod_q <= prod_nx;
            if (cur_dig > 4'd9) err <= 1'b1;
            if (last_dig) begin
              tx.out_valid <= 1'b0;
              done         <= 1'b1;
              result       <= sum_nx + prod_nx;
            end else begin
              tx.out_ch <= cur_op ? 8'h2A : 8'h2B;
            end
          end
        end
        OP: begin
          if (xfer) begin
            idx_q     <= idx_q + 4'd1;
            tx.out_ch <= 8'h30 + {4'h0, nxt_dig};
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/expr_tx.md
# expr_tx

Expression transmitter: serializes a latched list of decimal operands and `+`/`*` operators into an 8-bit ASCII character stream, one character per accepted transfer. The stream has the form digit ((`+`|`*`) digit)*. Alongside the stream, the block computes the expression's value with normal precedence (`*` before `+`). It sits upstream of the expression recognizer and drives that recognizer's character input, under a valid/ready handshake.

## Interface
- MAXN, default 8: maximum number of operands (2..15).
- W, default 16: width of the result; arithmetic wraps modulo 2^W.

- clk, input, 1: clock; all state changes on the rising edge.
- clr, input, 1: reset, asynchronous, active-high.
- start, input, 1: request strobe; sampled only in IDLE.
- count, input, 4: number of operands; legal range 1..MAXN.
- digits, input, 4*MAXN: operand i is digits[4i+3:4i].
- ops, input, MAXN-1: ops[i] is the operator between operand i and operand i+1; 0 = `+`, 1 = `*`.
- busy, output, 1: high from the cycle after an accepted start until the end of DONE.
- out_ch, output, 8: current ASCII character.
- out_valid, output, 1: out_ch is valid.
- out_ready, input, 1: the sink accepts the character.
- done, output, 1: one-cycle pulse after the last character transfers.
- result, output, W: expression value; held until the next accepted start.
- err, output, 1: sticky error flag; cleared by the next accepted start.

## Operation
- **States:** IDLE, DIGIT, OP, DONE.
- **IDLE:**
  - start=1 with 1 ≤ count ≤ MAXN: latch count, digits and ops; clear err, result, operand index i and the accumulators; go to DIGIT.
  - start=1 with count=0 or count>MAXN: set err=1, stay in IDLE, busy stays 0, no characters emitted.
- **DIGIT:**
  - out_valid=1, out_ch = 8'h30 + digit i.
  - A digit value >9 still emits 8'h30+value (`:` to `?`) and sets err=1.
- **OP:**
  - out_valid=1, out_ch = 8'h2B (`+`) if ops[i]=0, else 8'h2A (`*`).
- **Transfer:** occurs at the posedge where out_valid & out_ready.
  - DIGIT transfer with i < count-1: go to OP.
  - DIGIT transfer with i = count-1: go to DONE.
  - OP transfer: i increments, go to DIGIT.
- **DONE:**
  - done=1, out_valid=0, result = sum + prod (W bits); next cycle go to IDLE.
- **Evaluation** (updated on each DIGIT transfer, with d = digit i):
  - i=0: sum=0, prod=d.
  - Preceding op `+`: sum = sum + prod, prod = d.
  - Preceding op `*`: prod = prod × d.
  - All values truncated to W bits.
- start while busy is ignored: no relatch, no err.
- **clr** (any time, including mid-stream), immediately:
  - State → IDLE.
  - out_valid=0, out_ch=0, busy=0, done=0, result=0, err=0, accumulators=0.

## Timing
- All outputs are registered.
- **Reset values:** out_ch 8'h00, out_valid 0, busy 0, done 0, result 0, err 0.
- **Start latency:** start sampled at edge N → out_valid=1 with the first digit from edge N (visible in cycle N+1).
- **Handshake:**
  - While out_valid=1 and out_ready=0, out_ch is held stable.
  - out_valid never drops without a transfer, except on clr.
  - Back-to-back transfers are allowed; a new character follows every accepting edge.
- **Throughput:** with out_ready tied high, the stream occupies exactly 2·count−1 consecutive cycles, then DONE for 1 cycle, then IDLE. The next start is accepted on the IDLE cycle, i.e. 2·count+1 cycles after the previous start.
- **Result timing:** result updates in the same cycle that done=1 and is stable from then on.
- err may rise mid-stream on the transfer of an illegal digit, or one cycle after a rejected start.

## Test plan
- count=3, digits {1,2,3}, ops {0,1}, out_ready=1:
  - Stream is 31 2B 32 2A 33 on 5 consecutive cycles.
  - done pulses the next cycle; result=7; err=0.
- count=1, digit 9:
  - A single 8'h39 is emitted, no operator characters.
  - result=9; done follows 1 cycle after the transfer.
- Backpressure: out_ready=0 for 3 cycles while the `+` of "1+2*3" is presented:
  - out_ch stays 8'h2B with out_valid=1 throughout.
  - The stream resumes unchanged; result=7.
- count=8, all digits 9, all ops `*`:
  - Stream of 15 characters.
  - result = 9^8 mod 2^16 = 16'hD741.
- count=0 start:
  - err=1, busy=0, out_valid stays 0.
  - A subsequent legal start clears err.
- clr asserted mid-stream between two edges:
  - out_valid, busy and result go to 0 immediately, without waiting for a clock edge.
  - After release, a new start restarts from the first digit.
